// File: rtl/four_input_gate_pkg.sv
// Shared widths and gate_select encodings for the four-input reference gate tester.
package four_input_gate_pkg;

   localparam int unsigned PAT_W = 4;
   localparam int unsigned SEL_W = 3;

   localparam logic [SEL_W-1:0] SEL_AND  = 3'b000;
   localparam logic [SEL_W-1:0] SEL_OR   = 3'b001;
   localparam logic [SEL_W-1:0] SEL_NAND = 3'b010;
   localparam logic [SEL_W-1:0] SEL_NOR  = 3'b011;
   localparam logic [SEL_W-1:0] SEL_XOR  = 3'b100;
   localparam logic [SEL_W-1:0] SEL_XNOR = 3'b101;

endpackage

// File: rtl/four_input_and.sv
// Leaf combinational 4-input AND.
module four_input_and (
   input  logic A,
   input  logic B,
   input  logic C,
   input  logic D,
   output logic Y
);

   assign Y = A & B & C & D;

endmodule

// File: rtl/four_input_nand.sv
// Leaf combinational 4-input NAND.
module four_input_nand (
   input  logic A,
   input  logic B,
   input  logic C,
   input  logic D,
   output logic Y
);

   assign Y = ~(A & B & C & D);

endmodule

// File: rtl/mux_gate.sv
// Combinational selector choosing one reference gate result by gate_select code.
module mux_gate
   import four_input_gate_pkg::*;
#(
   parameter logic INVALID_Y = 1'b0
) (
   input  logic [SEL_W-1:0] select,
   input  logic             W_AND,
   input  logic             W_OR,
   input  logic             W_NAND,
   input  logic             W_NOR,
   input  logic             W_XOR,
   input  logic             W_XNOR,
   output logic             Y
);

   always_comb begin
      Y = INVALID_Y;
      case (select)
         SEL_AND:  Y = W_AND;
         SEL_OR:   Y = W_OR;
         SEL_NAND: Y = W_NAND;
         SEL_NOR:  Y = W_NOR;
         SEL_XOR:  Y = W_XOR;
         SEL_XNOR: Y = W_XNOR;
         default:  Y = INVALID_Y;
      endcase
   end

endmodule

// File: rtl/four_input_gate_ref.sv
// Reference gate model for IC testing: registers selected gate output and dut_op match.
// Define FOUR_INPUT_EXT_GATES_EN to enable OR/NOR/XOR/XNOR; otherwise those codes return AND.
module four_input_gate_ref
   import four_input_gate_pkg::*;
#(
   parameter logic INVALID_SEL_Y = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [PAT_W-1:0] pattern,
   input  logic             in_valid,
   input  logic [SEL_W-1:0] gate_select,
   input  logic             dut_op,
   output logic             y,
   output logic             y_valid,
   output logic             match
);

   logic w_and;
   logic w_nand;
   logic w_or;
   logic w_nor;
   logic w_xor;
   logic w_xnor;
   logic w_sel_y;
   logic r_y;
   logic r_match;
   logic r_y_valid;

   four_input_and u_and (
      .A (pattern[0]),
      .B (pattern[1]),
      .C (pattern[2]),
      .D (pattern[3]),
      .Y (w_and)
   );

   four_input_nand u_nand (
      .A (pattern[0]),
      .B (pattern[1]),
      .C (pattern[2]),
      .D (pattern[3]),
      .Y (w_nand)
   );

`ifdef FOUR_INPUT_EXT_GATES_EN
   assign w_or   = |pattern;
   assign w_nor  = ~w_or;
   assign w_xor  = ^pattern;
   assign w_xnor = ~w_xor;
`else
   // Reduced build: unsupported gate codes alias to the AND result.
   assign w_or   = w_and;
   assign w_nor  = w_and;
   assign w_xor  = w_and;
   assign w_xnor = w_and;
`endif

   mux_gate #(
      .INVALID_Y (INVALID_SEL_Y)
   ) u_mux (
      .select (gate_select),
      .W_AND  (w_and),
      .W_OR   (w_or),
      .W_NAND (w_nand),
      .W_NOR  (w_nor),
      .W_XOR  (w_xor),
      .W_XNOR (w_xnor),
      .Y      (w_sel_y)
   );

   // y/match hold when idle; y_valid pulses one cycle after each sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_y       <= 1'b0;
         r_match   <= 1'b0;
         r_y_valid <= 1'b0;
      end else begin
         r_y_valid <= in_valid;
         if (in_valid) begin
            r_y     <= w_sel_y;
            r_match <= (dut_op == w_sel_y);
         end
      end
   end

   assign y       = r_y;
   assign match   = r_match;
   assign y_valid = r_y_valid;

endmodule

// File: tb/tb_four_input_gate_ref.sv
// Table-driven bench for four_input_gate_ref plus hand sequences for hold and async reset.
module tb_four_input_gate_ref;
   import four_input_gate_pkg::*;

   typedef struct {
      logic [3:0] pat;
      logic [2:0] sel;
      logic       dut;
      logic       exp_y;
      logic       exp_m;
      string      name;
   } vec_t;

   logic       clk;
   logic       rst_n;
   logic [3:0] pattern;
   logic       in_valid;
   logic [2:0] gate_select;
   logic       dut_op;
   logic       y;
   logic       y_valid;
   logic       match;

   int checks;
   int failures;
   vec_t vecs[$];

   four_input_gate_ref dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pattern     (pattern),
      .in_valid    (in_valid),
      .gate_select (gate_select),
      .dut_op      (dut_op),
      .y           (y),
      .y_valid     (y_valid),
      .match       (match)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [3:0] p, input logic [2:0] s, input logic d,
                               input logic ey, input logic em, input string n);
      vec_t v;
      v.pat = p; v.sel = s; v.dut = d; v.exp_y = ey; v.exp_m = em; v.name = n;
      return v;
   endfunction

   initial begin
      checks = 0;
      failures = 0;
      rst_n = 1'b0;
      in_valid = 1'b0;
      pattern = 4'h0;
      gate_select = 3'b000;
      dut_op = 1'b0;

      // AND sweep: dut_op follows pattern[1], so match alternates by hand-known values
      for (int p = 0; p < 16; p++) begin
         logic [3:0] pp;
         logic ey;
         pp = 4'(p);
         ey = (pp == 4'b1111);
         vecs.push_back(mk(pp, SEL_AND, pp[1], ey, (pp[1] == ey), $sformatf("and_%0d", p)));
      end
      vecs.push_back(mk(4'b1111, SEL_NAND, 1'b0, 1'b0, 1'b1, "nand_1111"));
      vecs.push_back(mk(4'b0110, SEL_NAND, 1'b1, 1'b1, 1'b1, "nand_0110"));
      vecs.push_back(mk(4'b1111, SEL_AND,  1'b0, 1'b1, 1'b0, "and_mismatch"));
`ifdef FOUR_INPUT_EXT_GATES_EN
      vecs.push_back(mk(4'b0111, SEL_XOR,  1'b1, 1'b1, 1'b1, "xor_0111"));
      vecs.push_back(mk(4'b0111, SEL_XNOR, 1'b1, 1'b0, 1'b0, "xnor_0111"));
      vecs.push_back(mk(4'b0111, SEL_NOR,  1'b0, 1'b0, 1'b1, "nor_0111"));
      vecs.push_back(mk(4'b0100, SEL_OR,   1'b1, 1'b1, 1'b1, "or_0100"));
      vecs.push_back(mk(4'b0000, SEL_OR,   1'b1, 1'b0, 1'b0, "or_0000"));
      vecs.push_back(mk(4'b0110, SEL_XOR,  1'b0, 1'b0, 1'b1, "xor_0110"));
`else
      vecs.push_back(mk(4'b0111, SEL_XOR,  1'b1, 1'b0, 1'b0, "xor_as_and"));
      vecs.push_back(mk(4'b1111, SEL_XNOR, 1'b1, 1'b1, 1'b1, "xnor_as_and"));
      vecs.push_back(mk(4'b0111, SEL_NOR,  1'b0, 1'b0, 1'b1, "nor_as_and"));
      vecs.push_back(mk(4'b0100, SEL_OR,   1'b1, 1'b0, 1'b0, "or_as_and"));
      vecs.push_back(mk(4'b1111, SEL_OR,   1'b1, 1'b1, 1'b1, "or_as_and_1111"));
`endif
      vecs.push_back(mk(4'b1111, 3'b111, 1'b0, 1'b0, 1'b1, "invalid_111"));
      vecs.push_back(mk(4'b0000, 3'b110, 1'b1, 1'b0, 1'b0, "invalid_110"));
      vecs.push_back(mk(4'b1111, SEL_AND, 1'b1, 1'b1, 1'b1, "sel_change_back"));

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset_y", y, 1'b0);
      check("reset_match", match, 1'b0);
      check("reset_y_valid", y_valid, 1'b0);

      @(negedge clk);
      rst_n = 1'b1;

      // Back-to-back table application, one sample per cycle
      foreach (vecs[i]) begin
         @(negedge clk);
         in_valid = 1'b1;
         pattern = vecs[i].pat;
         gate_select = vecs[i].sel;
         dut_op = vecs[i].dut;
         @(posedge clk);
         #1;
         check({vecs[i].name, "_y"}, y, vecs[i].exp_y);
         check({vecs[i].name, "_match"}, match, vecs[i].exp_m);
         check({vecs[i].name, "_vld"}, y_valid, 1'b1);
      end

      // Idle hold: y=1, match=1 from last vector must persist with y_valid low
      @(negedge clk);
      in_valid = 1'b0;
      pattern = 4'b0000;
      dut_op = 1'b0;
      @(posedge clk);
      #1;
      check("hold_vld", y_valid, 1'b0);
      check("hold_y", y, 1'b1);
      check("hold_match", match, 1'b1);

      // Mid-stream asynchronous reset
      @(negedge clk);
      in_valid = 1'b1;
      pattern = 4'b1111;
      gate_select = SEL_AND;
      dut_op = 1'b1;
      @(posedge clk);
      #1;
      check("pre_rst_y", y, 1'b1);
      check("pre_rst_vld", y_valid, 1'b1);
      #1;
      rst_n = 1'b0;
      #1;
      check("async_rst_y", y, 1'b0);
      check("async_rst_match", match, 1'b0);
      check("async_rst_vld", y_valid, 1'b0);

      // Release with in_valid still high mid-cycle, then drop it: no stale result
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_idle_vld", y_valid, 1'b0);
      check("post_rst_idle_y", y, 1'b0);

      @(negedge clk);
      in_valid = 1'b1;
      pattern = 4'b1111;
      gate_select = SEL_AND;
      dut_op = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_first_vld", y_valid, 1'b1);
      check("post_rst_first_y", y, 1'b1);
      check("post_rst_first_match", match, 1'b1);

      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("final_vld_drop", y_valid, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/four_input_gate_ref.md
FOUR_INPUT_GATE_REF -- requirements
Module: four_input_gate_ref

Interface
REQ-001 SHALL have parameter INVALID_SEL_Y, default 1'b0: the value of y for unused gate_select codes 110 and 111.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port pattern, input, 4 bits: gate inputs, with A=pattern[0], B=[1], C=[2], D=[3].
REQ-005 SHALL have port in_valid, input, 1 bit: pattern, gate_select and dut_op are sampled this cycle.
REQ-006 SHALL have port gate_select, input, 3 bits: selects the reference gate function.
REQ-007 SHALL have port dut_op, input, 1 bit: output of the IC under test for the same pattern.
REQ-008 SHALL have port y, output, 1 bit: registered reference gate output.
REQ-009 SHALL have port y_valid, output, 1 bit: y and match are valid this cycle.
REQ-010 SHALL have port match, output, 1 bit: registered (dut_op == reference value).

Function
REQ-011 SHALL compute AND = A&B&C&D and NAND = ~AND combinationally from pattern.
REQ-012 SHALL use this gate_select encoding: 000 AND; 001 OR; 010 NAND; 011 NOR; 100 XOR (odd parity of A..D); 101 XNOR; 110 and 111 give INVALID_SEL_Y.
REQ-013 SHALL, on a clk edge with in_valid=1, register y <= selected value, match <= (dut_op == selected value), and y_valid <= 1.
REQ-014 SHALL, on a clk edge with in_valid=0, set y_valid <= 0 and hold y and match.
REQ-015 SHALL have a latency of exactly one cycle from in_valid to y_valid; back-to-back in_valid SHALL give back-to-back results with no bubbles.
REQ-016 SHALL use the gate_select value sampled in the same cycle as the pattern; a select change mid-stream affects only later samples.
REQ-017 SHALL evaluate all 16 patterns 0000..1111 exactly per truth table; for 4-input AND, y=1 only at 1111.

Reset
REQ-018 SHALL, while rst_n=0, force y=0, match=0 and y_valid=0 asynchronously, regardless of clk.
REQ-019 SHALL discard any in-flight sample when rst_n deasserts; the first y_valid occurs one edge after the first in_valid following reset release.

Configuration
REQ-020 SHALL, with macro FOUR_INPUT_EXT_GATES_EN defined, implement all six functions as in REQ-012.
REQ-021 SHALL, without FOUR_INPUT_EXT_GATES_EN, implement only AND (000) and NAND (010); codes 001, 011, 100 and 101 SHALL return the AND value, and 110/111 SHALL return INVALID_SEL_Y.

Structure
REQ-022 SHALL place the gate_select encoding constants (SEL_AND..SEL_XNOR) in shared package four_input_gate_pkg.
REQ-023 SHALL build from leaf combinational sub-modules four_input_and and four_input_nand (ports A, B, C, D, Y).
REQ-024 SHALL build the selector as combinational sub-module mux_gate (ports select, W_AND, W_OR, W_NAND, W_NOR, W_XOR, W_XNOR, Y).
REQ-025 SHALL contain no other state than the y, match and y_valid registers.

Verification
REQ-026 SHALL verify AND sweep: gate_select=000, patterns 0000..1111 with in_valid=1 each cycle -> y=1 only for 1111, y_valid=1 one cycle after each sample.
REQ-027 SHALL verify NAND sweep: gate_select=010, pattern 1111 -> y=0; pattern 0110 -> y=1; dut_op=1 with 0110 -> match=1.
REQ-028 SHALL verify mismatch: gate_select=000, pattern 1111, dut_op=0 -> y=1, match=0.
REQ-029 SHALL verify extended gates (macro defined): pattern 0111 with 100 -> y=1, 101 -> y=0, 011 -> y=0; with the macro undefined, 100 -> y=0 (the AND value).
REQ-030 SHALL verify reset mid-stream: rst_n=0 between clk edges after y=1, y_valid=1 -> y, match and y_valid go to 0 immediately.
REQ-031 SHALL verify invalid select: gate_select=111, any pattern -> y=INVALID_SEL_Y (0 by default).
